// File: rtl/dap_swd_transfer.sv
// SWD transfer engine: frames request/ACK/data/idle into DAP_Seqence bit sequences.
// Define DAP_SWD_DATA_PHASE_EN to run a dummy data phase after WAIT/FAULT.
module dap_swd_transfer #(
    parameter int unsigned SEQ_GAP         = 8,
    parameter logic [3:0]  SEQ_CMD_SWD_SEQ = 4'h3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        xfer_req_valid,
    output logic        xfer_req_ready,
    input  logic        xfer_apndp,
    input  logic        xfer_rnw,
    input  logic [1:0]  xfer_addr,
    input  logic [31:0] xfer_wdata,
    input  logic [1:0]  cfg_turn,
    input  logic [6:0]  cfg_idle,
    input  logic [15:0] cfg_retry,
    output logic        xfer_rsp_valid,
    output logic [2:0]  xfer_rsp_ack,
    output logic [31:0] xfer_rsp_rdata,
    output logic        xfer_rsp_perr,
    output logic        seq_tx_valid,
    output logic [15:0] seq_tx_cmd,
    output logic [63:0] seq_tx_data,
    input  logic        seq_rx_valid,
    input  logic [63:0] seq_rx_data,
    input  logic        seq_tx_full
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACK,
        S_DATA,
        S_IDLE_CYC,
        S_RESP
    } state_t;

    typedef enum logic {
        PH_TX,
        PH_GAP
    } phase_t;

    localparam int unsigned GW = $clog2(SEQ_GAP + 1);
    localparam logic [2:0] ACK_OK   = 3'b001;
    localparam logic [2:0] ACK_WAIT = 3'b010;

    state_t        state_q, state_d, nxt, post_data;
    phase_t        phase_q, phase_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          rx_prev_q;
    logic [63:0]   rx_q, rx_d;

    logic          apndp_q, rnw_q;
    logic [1:0]    addr_q, turn_q;
    logic [31:0]   wdata_q;
    logic [6:0]    idle_q;
    logic [15:0]   retry_q, retry_d;

    logic [2:0]    ack_q, ack_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          perr_q, perr_d;
    logic          rsp_valid_q, rsp_valid_d;

    logic          tx_valid_q, tx_valid_d, tx_load;
    logic [15:0]   tx_cmd_q, cmd_w;
    logic [63:0]   tx_data_q, data_w;
    logic          cmd_t;
    logic [6:0]    cmd_n;

    logic          accept, rx_rise, gap_done, go;
    logic          e_apndp, e_rnw;
    logic [1:0]    e_addr;
    logic [5:0]    ack_base;
    logic [2:0]    ack_dec;
    logic [31:0]   rd_dec;
    logic          rd_par;
    logic          unused_ok;

    assign accept  = (state_q == S_IDLE) & xfer_req_valid;
    assign rx_rise = seq_rx_valid & ~rx_prev_q;

    assign e_apndp = accept ? xfer_apndp : apndp_q;
    assign e_rnw   = accept ? xfer_rnw : rnw_q;
    assign e_addr  = accept ? xfer_addr : addr_q;

    // Ack sits after the turnaround; writes also carry the host turnaround.
    assign ack_base = rnw_q ? 6'd2 : 6'(turn_q) + 6'd3;
    assign ack_dec  = {rx_q[ack_base - 6'd2],
                       rx_q[ack_base - 6'd1],
                       rx_q[ack_base]};

    always_comb begin
        rd_dec = '0;
        for (int k = 0; k < 32; k++) begin
            rd_dec[k] = rx_q[6'(33 - k) + 6'(turn_q)];
        end
    end

    assign rd_par = rx_q[6'(turn_q) + 6'd1];

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        gap_d       = gap_q;
        rx_d        = rx_q;
        retry_d     = retry_q;
        ack_d       = ack_q;
        rdata_d     = rdata_q;
        perr_d      = perr_q;
        tx_valid_d  = tx_valid_q;
        tx_load     = 1'b0;
        rsp_valid_d = 1'b0;
        gap_done    = 1'b0;
        go          = 1'b0;
        nxt         = state_q;
        post_data   = (idle_q == 7'd0) ? S_RESP : S_IDLE_CYC;

        case (state_q)
            S_IDLE: begin
                if (xfer_req_valid) begin
                    go      = 1'b1;
                    nxt     = S_REQ;
                    retry_d = cfg_retry;
                    ack_d   = '0;
                    rdata_d = '0;
                    perr_d  = 1'b0;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                if (phase_q == PH_TX) begin
                    if (rx_rise) begin
                        rx_d       = seq_rx_data;
                        tx_valid_d = 1'b0;
                        phase_d    = PH_GAP;
                        gap_d      = '0;
                    end
                end else if (seq_rx_valid) begin
                    gap_d = '0;
                end else if (gap_q != GW'(SEQ_GAP - 1)) begin
                    gap_d = gap_q + 1'b1;
                end else begin
                    gap_done = 1'b1;
                end
            end
        endcase

        if (gap_done) begin
            go = 1'b1;
            case (state_q)
                S_REQ: nxt = S_ACK;
                S_ACK: begin
                    ack_d = ack_dec;
                    if (ack_dec == ACK_OK) begin
                        nxt = S_DATA;
                    end else if (ack_dec == ACK_WAIT && retry_q != '0) begin
                        retry_d = retry_q - 1'b1;
                        nxt     = S_REQ;
                    end else begin
`ifdef DAP_SWD_DATA_PHASE_EN
                        nxt = S_DATA;
`else
                        nxt = post_data;
`endif
                    end
                end
                S_DATA: begin
                    if (rnw_q && ack_q == ACK_OK) begin
                        rdata_d = rd_dec;
                        perr_d  = rd_par ^ (^rd_dec);
                    end
                    nxt = post_data;
                end
                default: nxt = S_RESP;
            endcase
        end

        if (go) begin
            state_d = nxt;
            if (nxt == S_RESP) begin
                rsp_valid_d = 1'b1;
            end else begin
                phase_d    = PH_TX;
                tx_valid_d = 1'b1;
                tx_load    = 1'b1;
            end
        end
    end

    // Command for the state being entered; only sampled when tx_load is set.
    always_comb begin
        cmd_t  = 1'b0;
        cmd_n  = '0;
        data_w = '0;
        case (state_d)
            S_REQ: begin
                cmd_n         = 7'd8;
                data_w[63:56] = {1'b1, e_apndp, e_rnw, e_addr[0], e_addr[1],
                                 e_apndp ^ e_rnw ^ e_addr[0] ^ e_addr[1],
                                 1'b0, 1'b1};
            end
            S_ACK: begin
                cmd_t = 1'b1;
                cmd_n = rnw_q ? 7'(turn_q) + 7'd4
                              : {4'd0, turn_q, 1'b0} + 7'd5;
            end
            S_DATA: begin
                if (rnw_q) begin
                    cmd_t = 1'b1;
                    cmd_n = 7'(turn_q) + 7'd34;
                end else begin
                    cmd_n = 7'd33;
                    if (ack_d == ACK_OK) begin
                        for (int k = 0; k < 32; k++) begin
                            data_w[63-k] = wdata_q[k];
                        end
                        data_w[31] = ^wdata_q;
                    end
                end
            end
            S_IDLE_CYC: cmd_n = idle_q;
            default: ;
        endcase
    end

    assign cmd_w = {SEQ_CMD_SWD_SEQ, 4'h0, cmd_t, cmd_n};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_TX;
            gap_q       <= '0;
            rx_prev_q   <= 1'b0;
            rx_q        <= '0;
            apndp_q     <= 1'b0;
            rnw_q       <= 1'b0;
            addr_q      <= '0;
            turn_q      <= '0;
            wdata_q     <= '0;
            idle_q      <= '0;
            retry_q     <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            perr_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_cmd_q    <= '0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            gap_q       <= gap_d;
            rx_prev_q   <= seq_rx_valid;
            rx_q        <= rx_d;
            retry_q     <= retry_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            perr_q      <= perr_d;
            rsp_valid_q <= rsp_valid_d;
            tx_valid_q  <= tx_valid_d;
            if (accept) begin
                apndp_q <= xfer_apndp;
                rnw_q   <= xfer_rnw;
                addr_q  <= xfer_addr;
                wdata_q <= xfer_wdata;
                turn_q  <= cfg_turn;
                idle_q  <= cfg_idle;
            end
            if (tx_load) begin
                tx_cmd_q  <= cmd_w;
                tx_data_q <= data_w;
            end
        end
    end

    assign xfer_req_ready = (state_q == S_IDLE);
    assign xfer_rsp_valid = rsp_valid_q;
    assign xfer_rsp_ack   = ack_q;
    assign xfer_rsp_rdata = rdata_q;
    assign xfer_rsp_perr  = perr_q;
    assign seq_tx_valid   = tx_valid_q;
    assign seq_tx_cmd     = tx_cmd_q;
    assign seq_tx_data    = tx_data_q;

    assign unused_ok = &{1'b0, seq_tx_full};

endmodule

// File: tb/tb_dap_swd_transfer.sv
// Scoreboard bench: sequencer model, command monitor and response monitor.
module tb_dap_swd_transfer;

    localparam logic [3:0] CMD = 4'h3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        xfer_req_valid = 1'b0;
    logic        xfer_req_ready;
    logic        xfer_apndp = 1'b0;
    logic        xfer_rnw = 1'b0;
    logic [1:0]  xfer_addr = '0;
    logic [31:0] xfer_wdata = '0;
    logic [1:0]  cfg_turn = '0;
    logic [6:0]  cfg_idle = '0;
    logic [15:0] cfg_retry = '0;
    logic        xfer_rsp_valid;
    logic [2:0]  xfer_rsp_ack;
    logic [31:0] xfer_rsp_rdata;
    logic        xfer_rsp_perr;
    logic        seq_tx_valid;
    logic [15:0] seq_tx_cmd;
    logic [63:0] seq_tx_data;
    logic        seq_rx_valid;
    logic [63:0] seq_rx_data;
    logic        seq_tx_full = 1'b0;

    always #5 clk = ~clk;

    dap_swd_transfer dut (
        .clk(clk),
        .resetn(resetn),
        .xfer_req_valid(xfer_req_valid),
        .xfer_req_ready(xfer_req_ready),
        .xfer_apndp(xfer_apndp),
        .xfer_rnw(xfer_rnw),
        .xfer_addr(xfer_addr),
        .xfer_wdata(xfer_wdata),
        .cfg_turn(cfg_turn),
        .cfg_idle(cfg_idle),
        .cfg_retry(cfg_retry),
        .xfer_rsp_valid(xfer_rsp_valid),
        .xfer_rsp_ack(xfer_rsp_ack),
        .xfer_rsp_rdata(xfer_rsp_rdata),
        .xfer_rsp_perr(xfer_rsp_perr),
        .seq_tx_valid(seq_tx_valid),
        .seq_tx_cmd(seq_tx_cmd),
        .seq_tx_data(seq_tx_data),
        .seq_rx_valid(seq_rx_valid),
        .seq_rx_data(seq_rx_data),
        .seq_tx_full(seq_tx_full)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [79:0] exp_cmd[$];
    logic [35:0] exp_rsp[$];
    logic [63:0] rx_fifo[$];

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic push_cmd(input logic t, input int n, input logic [63:0] d);
        exp_cmd.push_back({CMD, 4'h0, t, 7'(n), d});
    endtask

    task automatic push_rsp(input logic [2:0] a, input logic p,
                            input logic [31:0] d);
        exp_rsp.push_back({a, p, d});
    endtask

    function automatic logic [63:0] ack_rx(input int n, input int t,
                                           input logic [2:0] a);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 3; k++) r[n-1-t-k] = a[k];
        return r;
    endfunction

    function automatic logic [63:0] rd_rx(input int t, input logic [31:0] d,
                                          input logic p);
        logic [63:0] r;
        int n;
        n = 33 + t;
        r = '0;
        for (int k = 0; k < 32; k++) r[n-1-k] = d[k];
        r[n-33] = p;
        return r;
    endfunction

    // Sequencer model: answer each command a few cycles later with a
    // multi-cycle rx_valid level; input sequences pop the rx fifo.
    logic [1:0] m_st;
    logic [2:0] m_cnt;
    logic       m_t;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_st         <= 2'd0;
            m_cnt        <= 3'd0;
            m_t          <= 1'b0;
            seq_rx_valid <= 1'b0;
            seq_rx_data  <= '0;
        end else begin
            case (m_st)
                2'd0: if (seq_tx_valid) begin
                    m_t   <= seq_tx_cmd[7];
                    m_cnt <= 3'd0;
                    m_st  <= 2'd1;
                end
                2'd1: if (m_cnt == 3'd2) begin
                    seq_rx_valid <= 1'b1;
                    if (m_t && rx_fifo.size() != 0)
                        seq_rx_data <= rx_fifo.pop_front();
                    else
                        seq_rx_data <= '0;
                    m_cnt <= 3'd0;
                    m_st  <= 2'd2;
                end else begin
                    m_cnt <= m_cnt + 3'd1;
                end
                2'd2: if (m_cnt == 3'd2) begin
                    seq_rx_valid <= 1'b0;
                    m_st         <= 2'd3;
                end else begin
                    m_cnt <= m_cnt + 3'd1;
                end
                default: if (!seq_tx_valid) m_st <= 2'd0;
            endcase
        end
    end

    logic tx_prev = 1'b0;

    initial forever begin
        @(negedge clk);
        if (resetn && seq_tx_valid && !tx_prev) begin
            if (exp_cmd.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL cmd_extra: got %h/%h want none",
                         seq_tx_cmd, seq_tx_data);
            end else begin
                logic [79:0] e;
                e = exp_cmd.pop_front();
                check("cmd_word", 64'(seq_tx_cmd), 64'(e[79:64]));
                check("cmd_data", seq_tx_data, e[63:0]);
            end
        end
        tx_prev = seq_tx_valid;
    end

    initial forever begin
        @(negedge clk);
        if (xfer_rsp_valid) begin
            if (exp_rsp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_extra: got ack %h rdata %h perr %b want none",
                         xfer_rsp_ack, xfer_rsp_rdata, xfer_rsp_perr);
            end else begin
                check("rsp", 64'({xfer_rsp_ack, xfer_rsp_perr, xfer_rsp_rdata}),
                      64'(exp_rsp.pop_front()));
            end
        end
    end

    task automatic start(input logic ap, input logic rnw, input logic [1:0] a,
                         input logic [31:0] wd, input logic [1:0] turn,
                         input logic [6:0] idle, input logic [15:0] retry);
        int k;
        k = 0;
        while (!xfer_req_ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("ready_before", 64'(xfer_req_ready), 64'd1);
        xfer_apndp     = ap;
        xfer_rnw       = rnw;
        xfer_addr      = a;
        xfer_wdata     = wd;
        cfg_turn       = turn;
        cfg_idle       = idle;
        cfg_retry      = retry;
        xfer_req_valid = 1'b1;
        @(negedge clk);
        xfer_req_valid = 1'b0;
        check("ready_low", 64'(xfer_req_ready), 64'd0);
        check("tx_valid_rise", 64'(seq_tx_valid), 64'd1);
        xfer_apndp = ~ap;
        xfer_rnw   = ~rnw;
        xfer_addr  = ~a;
        xfer_wdata = ~wd;
        cfg_turn   = ~turn;
        cfg_idle   = idle ^ 7'h55;
        cfg_retry  = ~retry;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while ((exp_cmd.size() != 0 || exp_rsp.size() != 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({name, "_timeout"}, 64'(exp_cmd.size() + exp_rsp.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx", {seq_tx_valid, 15'd0, seq_tx_cmd, 32'd0}, 64'd0);
        check("rst_txdata", seq_tx_data, 64'd0);
        check("rst_rsp", 64'({xfer_rsp_valid, xfer_rsp_ack, xfer_rsp_perr,
                              xfer_rsp_rdata}), 64'd0);
        check("rst_ready", 64'(xfer_req_ready), 64'd1);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // DP read A=0, t=1, idle 0
        push_cmd(1'b0, 8, {8'hA5, 56'h0});
        push_cmd(1'b1, 4, 64'h0);
        push_cmd(1'b1, 34, 64'h0);
        rx_fifo.push_back(ack_rx(4, 1, 3'b001));
        rx_fifo.push_back(rd_rx(1, 32'h12345678, 1'b1));
        push_rsp(3'd1, 1'b0, 32'h12345678);
        start(1'b0, 1'b1, 2'b00, 32'h0, 2'd0, 7'd0, 16'd0);
        wait_done("dp_read");

        // AP write A=1 0xDEADBEEF, idle 8: request byte 0x8B, wire 0xD1
        push_cmd(1'b0, 8, {8'hD1, 56'h0});
        push_cmd(1'b1, 5, 64'h0);
        push_cmd(1'b0, 33, 64'hF77DB57B_00000000);
        push_cmd(1'b0, 8, 64'h0);
        rx_fifo.push_back(ack_rx(5, 1, 3'b001));
        push_rsp(3'd1, 1'b0, 32'h0);
        start(1'b1, 1'b0, 2'b01, 32'hDEADBEEF, 2'd0, 7'd8, 16'd0);
        wait_done("ap_write");

        // Retry success: WAIT, WAIT, OK with t=2, A=2
        for (int i = 0; i < 3; i++) begin
            push_cmd(1'b0, 8, {8'hA9, 56'h0});
            push_cmd(1'b1, 5, 64'h0);
        end
        push_cmd(1'b1, 35, 64'h0);
        rx_fifo.push_back(ack_rx(5, 2, 3'b010));
        rx_fifo.push_back(ack_rx(5, 2, 3'b010));
        rx_fifo.push_back(ack_rx(5, 2, 3'b001));
        rx_fifo.push_back(rd_rx(2, 32'h000000FF, 1'b0));
        push_rsp(3'd1, 1'b0, 32'h000000FF);
        start(1'b0, 1'b1, 2'b10, 32'h0, 2'd1, 7'd0, 16'd3);
        wait_done("retry_ok");

        // Retry exhausted: single REQ, WAIT reported
        push_cmd(1'b0, 8, {8'hB1, 56'h0});
        push_cmd(1'b1, 4, 64'h0);
`ifdef DAP_SWD_DATA_PHASE_EN
        push_cmd(1'b1, 34, 64'h0);
`endif
        push_cmd(1'b0, 3, 64'h0);
        rx_fifo.push_back(ack_rx(4, 1, 3'b010));
        push_rsp(3'd2, 1'b0, 32'h0);
        start(1'b0, 1'b1, 2'b01, 32'h0, 2'd0, 7'd3, 16'd0);
        wait_done("retry_exh");

        // FAULT on AP write A=3, t=3, idle 0
        push_cmd(1'b0, 8, {8'hDD, 56'h0});
        push_cmd(1'b1, 9, 64'h0);
`ifdef DAP_SWD_DATA_PHASE_EN
        push_cmd(1'b0, 33, 64'h0);
`endif
        rx_fifo.push_back(ack_rx(9, 3, 3'b100));
        push_rsp(3'd4, 1'b0, 32'h0);
        start(1'b1, 1'b0, 2'b11, 32'hCAFEF00D, 2'd2, 7'd0, 16'd5);
        wait_done("fault");

        // Parity error at maximum turnaround t=4
        push_cmd(1'b0, 8, {8'hBD, 56'h0});
        push_cmd(1'b1, 7, 64'h0);
        push_cmd(1'b1, 37, 64'h0);
        rx_fifo.push_back(ack_rx(7, 4, 3'b001));
        rx_fifo.push_back(rd_rx(4, 32'h00000001, 1'b0));
        push_rsp(3'd1, 1'b1, 32'h00000001);
        start(1'b0, 1'b1, 2'b11, 32'h0, 2'd3, 7'd0, 16'd0);
        wait_done("perr");

        // Reset in the middle of the read data phase
        push_cmd(1'b0, 8, {8'hA5, 56'h0});
        push_cmd(1'b1, 4, 64'h0);
        push_cmd(1'b1, 34, 64'h0);
        rx_fifo.push_back(ack_rx(4, 1, 3'b001));
        start(1'b0, 1'b1, 2'b00, 32'h0, 2'd0, 7'd0, 16'd0);
        begin
            int k;
            k = 0;
            while (!(seq_tx_valid && seq_tx_cmd[6:0] == 7'd34) && k < 500) begin
                @(negedge clk);
                k++;
            end
            check("data_cmd_seen", 64'(seq_tx_cmd[6:0]), 64'd34);
        end
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("mid_rst_tx_valid", 64'(seq_tx_valid), 64'd0);
        check("mid_rst_ready", 64'(xfer_req_ready), 64'd1);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        check("mid_rst_cmds", 64'(exp_cmd.size()), 64'd0);
        check("mid_rst_rx", 64'(rx_fifo.size()), 64'd0);

        // Normal read after the abandoned one
        push_cmd(1'b0, 8, {8'hA5, 56'h0});
        push_cmd(1'b1, 4, 64'h0);
        push_cmd(1'b1, 34, 64'h0);
        rx_fifo.push_back(ack_rx(4, 1, 3'b001));
        rx_fifo.push_back(rd_rx(1, 32'h80000000, 1'b1));
        push_rsp(3'd1, 1'b0, 32'h80000000);
        start(1'b0, 1'b1, 2'b00, 32'h0, 2'd0, 7'd0, 16'd0);
        wait_done("after_rst");

        repeat (20) @(negedge clk);
        check("queues_empty", 64'(exp_cmd.size() + exp_rsp.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dap_swd_transfer.md
# dap_swd_transfer

- Executes one SWD transfer (request, ACK, data, idle cycles) per accepted upstream request.
- Breaks each transfer into raw bit sequences for the DAP_Seqence sequencer; all SWD framing is done here.
- Handles WAIT retry and checks read-data parity.
- Sits between the DAP command processor (transfer requests) and DAP_Seqence (`SEQ_CMD_SWD_SEQ` commands), entirely in the controller `clk` domain.

## Interface
- SEQ_GAP, 8: `clk` cycles `seq_tx_valid` stays low between two sequencer commands. Must cover ≥2 `sclk` periods plus the sequencer's rx-valid synchroniser.
- clk  input  1  controller clock
- resetn  input  1  asynchronous, active-low reset
- xfer_req_valid  input  1  transfer request valid
- xfer_req_ready  output  1  high only in IDLE
- xfer_apndp  input  1  0=DP, 1=AP
- xfer_rnw  input  1  1=read
- xfer_addr  input  2  A[3:2]
- xfer_wdata  input  32  write data
- cfg_turn  input  2  turnaround length − 1 (1..4 clocks)
- cfg_idle  input  7  idle clocks after the transfer (0..127)
- cfg_retry  input  16  WAIT retries allowed
- xfer_rsp_valid  output  1  one-cycle response pulse
- xfer_rsp_ack  output  3  ACK as received: bit0 = first wire bit (1=OK, 2=WAIT, 4=FAULT)
- xfer_rsp_rdata  output  32  read data
- xfer_rsp_perr  output  1  read parity mismatch
- seq_tx_valid, seq_tx_cmd[15:0], seq_tx_data[63:0]  output  command to DAP_Seqence
- seq_rx_valid  input  1  multi-cycle level from the sequencer; only its rising edge is used
- seq_rx_data  input  64  received bits; first wire bit at index count−1
- seq_tx_full  input  1  ignored

## Operation
- **Command word:** {`SEQ_CMD_SWD_SEQ` (from DAP_Cmd.v), 4'h0, T, count[6:0]}.
  - T=1 means input/tristate.
  - The sequencer shifts `seq_tx_data` out MSB-first, so wire bit p sits at `seq_tx_data[63−p]`; unused bits are 0.
- **Command issue (ISSUE → WAIT_RX → GAP):**
  - Raise `seq_tx_valid`; hold it and cmd/data stable until a `seq_rx_valid` rising edge.
  - On that edge, capture `seq_rx_data` and drop `seq_tx_valid`.
  - Wait until `seq_rx_valid` is low, then SEQ_GAP cycles, then go to the next state.
- **States:** IDLE, REQ, ACK, DATA, IDLE_CYC, RESP.
  - **IDLE:** on `xfer_req_valid & xfer_req_ready`, latch request and config; load the retry counter from `cfg_retry`.
  - **REQ:** issue T=0, count 8. Wire order: 1, APnDP, RnW, A2, A3, parity (XOR of those four), 0, 1.
  - **ACK:** t = cfg_turn+1. Issue T=1 with count n = t+3 for reads, or 2t+3 for writes (host turnaround included). Ack bit k = `rx[n−1−t−k]`.
  - **ACK outcomes:**
    - OK → DATA.
    - WAIT with retry counter ≠ 0 → decrement the counter, go to REQ.
    - WAIT with counter exhausted, FAULT, or any other value → IDLE_CYC, with no data phase.
  - **DATA, read:** T=1, n = 33+t. Data bit k = `rx[n−1−k]`; parity = `rx[n−33]`. `perr` = parity ≠ ^data.
  - **DATA, write:** T=0, n = 33. Data bit k at `seq_tx_data[63−k]`; ^wdata at `[31]`.
  - **IDLE_CYC:** issue T=0 with count `cfg_idle` and all-zero data. Skipped when `cfg_idle` = 0.
  - **RESP:** pulse `xfer_rsp_valid`, go to IDLE. `rdata` = 0 for writes and non-OK reads; `perr` is valid only for OK reads.

## Timing
- **Reset values:**
  - `seq_tx_valid`, `seq_tx_cmd`, `seq_tx_data`, `xfer_rsp_*` = 0.
  - `xfer_req_ready` = 1; state = IDLE.
- **Mid-transfer reset:** abandons the transfer immediately with no response. The sequencer is reset by the same `resetn`.
- `seq_tx_valid` rises in the cycle after acceptance.
- `xfer_rsp_valid` fires one cycle after leaving the last GAP.
- `xfer_req_ready` is low from the cycle after acceptance through the RESP cycle.
- A `seq_rx_valid` edge arriving while `seq_tx_valid` is low is ignored.
- `seq_rx_valid` still high at the start of GAP extends GAP.
- `cfg_*` changes during a transfer have no effect until the next acceptance.

## Configuration
- DAP_SWD_DATA_PHASE_EN defined: on WAIT/FAULT, a data phase still runs before IDLE_CYC.
  - Read: T=1, n = 33+t, data discarded.
  - Write: T=0, n = 33, zeros.
  - The response then reports the ACK, `rdata` = 0, `perr` = 0.
- DAP_SWD_DATA_PHASE_EN undefined: no data phase after WAIT/FAULT.

## Test plan
- **DP read, addr 0, t=1, idle 0:**
  - Expect REQ cmd T=0/count 8 with data[63:56] = 0xA5.
  - ACK cmd count 4.
  - DATA cmd count 34.
  - Sequencer model returns 0x12345678 with correct parity → rsp ack=1, rdata=0x12345678, perr=0, and no IDLE_CYC cmd.
- **AP write, A=1, wdata 0xDEADBEEF, idle 8:**
  - Expect request byte 0x8B.
  - ACK count 5.
  - DATA count 33 with parity bit[31]=0.
  - IDLE cmd count 8, data 0.
  - Response ack=1.
- **Retry success, cfg_retry=3:** model answers WAIT twice then OK → 3 REQ commands, one response ack=1.
- **Retry exhausted, cfg_retry=0:** model answers WAIT → exactly one REQ; response ack=2. DATA count 34 appears only with the macro defined.
- **Parity error:** read returns 0x00000001 with parity 0 → ack=1, rdata=1, perr=1.
- **Reset mid-DATA:** assert `resetn` low → `seq_tx_valid`=0, ready=1, no `xfer_rsp_valid`. Next request completes normally.
